// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and load/store.
// MEM has priority; accesses are split into byte transfers and reassembled little-endian.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_len;
  logic [2:0]  r_cnt;
  logic [31:0] r_buf;
  logic        r_own_if;

  logic [2:0]  w_mem_n;
  logic [2:0]  w_cnt_inc;
  logic [31:0] w_next_a;
  logic [1:0]  w_lane;
  logic [31:0] w_buf_cap;
  logic [7:0]  w_wbyte;

  // In READ, r_cnt counts cycles spent there: ram_din in cycle r_cnt belongs to lane r_cnt-1.
  always_comb begin
    w_mem_n   = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    w_cnt_inc = r_cnt + 3'd1;
    w_next_a  = r_addr + {29'd0, w_cnt_inc};
    w_lane    = r_cnt[1:0] - 2'd1;
    w_buf_cap = r_buf;
    w_buf_cap[{w_lane, 3'b000} +: 8] = ram_din;
    w_wbyte   = mem_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
  end

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_own_if  <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          ram_wr   <= 1'b0;
          r_cnt    <= '0;
          if (mem_req) begin
            r_own_if <= 1'b0;
            r_addr   <= mem_addr;
            r_len    <= w_mem_n;
            r_buf    <= '0;
            ram_a    <= mem_addr;
            if (mem_we) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
              r_state  <= S_WRITE;
            end else begin
              r_state  <= S_READ;
            end
          end else if (if_req) begin
            r_own_if <= 1'b1;
            r_addr   <= if_addr;
            r_len    <= 3'd4;
            r_buf    <= '0;
            ram_a    <= if_addr;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_cnt != 3'd0)
            r_buf <= w_buf_cap;
          if (r_cnt == r_len) begin
            r_state <= S_DONE;
            if (r_own_if) begin
              if_done <= 1'b1;
              if_data <= w_buf_cap;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= w_buf_cap;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc < r_len)
              ram_a <= w_next_a;
          end
        end
        S_WRITE: begin
          if (w_cnt_inc < r_len) begin
            ram_a    <= w_next_a;
            ram_dout <= w_wbyte;
            r_cnt    <= w_cnt_inc;
          end else begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). It serialises each 8/16/32-bit access into byte transfers, assembles the little-endian result, and reports completion. It also drives the stall requests that freeze the IF/ID, ID/EX and later pipeline registers. It sits between the pipeline front/back ends and the top-level RAM pins.

## Interface

- No parameters; address width fixed at 32, RAM data width fixed at 8.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when 0 the block holds all state
- if_req  in  1  fetch request; held high with stable if_addr until if_done
- if_addr  in  32  fetch byte address (always a 4-byte read)
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word
- mem_req  in  1  load/store request; inputs held stable until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data; byte k taken from bits [8k+7:8k]
- mem_done  out  1  one-cycle pulse: access finished, mem_rdata valid for loads
- mem_rdata  out  32  raw load data, zero-filled above N bytes; sign extension is done by MEM
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  mem_req & ~mem_done (combinational)
- ram_a  out  32  RAM byte address (registered)
- ram_dout  out  8  RAM write data (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_din  in  8  RAM read data; returns the byte for the ram_a presented one cycle earlier

## Operation

- States: IDLE, READ, WRITE, DONE.
- Per-access registers: base address, length N (1/2/4), byte counter cnt, assembly buffer, owner (IF or MEM).
- **IDLE**
  - mem_req has priority over if_req.
  - On grant, latch the address and N, clear the buffer, and set ram_a = addr.
  - Enter WRITE if mem_we is 1, otherwise READ.
- **READ**
  - Issue addresses addr+1 … addr+N-1 on successive cycles.
  - Capture ram_din into byte lane i one cycle after address addr+i was presented.
  - After the last byte is captured, enter DONE.
- **WRITE**
  - Cycle k (k = 0..N-1): ram_a = addr+k, ram_dout = byte k, ram_wr = 1.
  - Then enter DONE with ram_wr = 0.
- **DONE**
  - Pulse the owner's done for one cycle; drive the buffer on if_data/mem_rdata.
  - Return to IDLE without sampling requests, so the requester can drop or change req.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF+1 wraps to 0x00000000.
- No preemption. A mem_req arriving during an IF access waits for IDLE.
- Requests in the same cycle: MEM wins; IF is served afterwards.
- When no access is in progress: ram_wr = 0, and ram_a holds its last value.
- if_data and mem_rdata hold their last value between accesses.

## Timing

- Reset: state IDLE; cnt, buffer, ram_a, ram_dout, if_data, mem_rdata = 0; ram_wr, if_done, mem_done = 0.
- Reset mid-access aborts it: no done pulse, and ram_wr = 0 from the next cycle.
- rdy = 0 freezes state, counters, buffer and registered outputs. The RAM is frozen by the same rdy, so ram_din stays consistent across the gap.
- Cycle 0 = IDLE cycle in which req is sampled.
  - Read of N bytes: done in cycle N+2. Word read: done in cycle 6, IDLE in cycle 7.
  - Write of N bytes: ram_wr = 1 in cycles 1..N, done in cycle N+1.
- Minimum spacing between grants: one IDLE cycle after DONE.

## Test plan

- **Word fetch:** RAM[0x100..0x103] = 13 00 00 00; if_req, if_addr = 0x100 → ram_a = 0x100..0x103 in cycles 1–4; if_done only in cycle 6; if_data = 0x00000013.
- **Simultaneous requests:** if_req (0x0) and mem_req load byte at 0x20 = 0xAB in the same cycle → mem_done first, mem_rdata = 0x000000AB; IF access starts after DONE/IDLE; stall_if stays high until if_done.
- **Half store:** addr 0x41, mem_wdata = 0xDEADBEEF → ram_wr in exactly 2 cycles, (0x41, 0xEF) then (0x42, 0xBE); mem_done in cycle 3; RAM[0x43] unchanged.
- **Wrap-around:** word load at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order.
- **rdy gaps:** drop rdy for 3 cycles mid word load → identical data, done delayed by exactly 3 cycles, no ram_wr glitch.
- **Reset mid-store:** assert rst during the 2nd byte of a word store → no mem_done, ram_wr = 0 the next cycle, all outputs at reset values.
